// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared core widths and the register-address type.
package rv_core_pkg;
    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW = $clog2(DEF_NREG);
    typedef logic [DEF_AW-1:0] reg_addr_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: write bypass and busy qualification for one read port.
module rf_read_port
    import rv_core_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0]   addr,
    input  logic            valid,
    input  logic [XLEN-1:0] stored,
    input  logic            busy_bit,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            busy
);
    logic hit_a, hit_b;
    assign hit_a = wa_en && wa_addr == addr;
    assign hit_b = wb_en && wb_addr == addr;
    // Port A is the younger instruction, so it wins the bypass.
    assign data = !valid ? '0 : hit_a ? wa_data : hit_b ? wb_data : stored;
    assign busy = valid && busy_bit && !hit_b;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/2W register file with a busy scoreboard for long-latency ops.
module regfile_scoreboard
    import rv_core_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            flush,
    output logic [AW:0]     pending_cnt
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            wa_ok, wb_ok, iss_ok, rs1_ok, rs2_ok;

    // x0 and addresses beyond NREG are never stored, tracked or read.
    function automatic logic live(input logic [AW-1:0] a);
        return a != '0 && 32'(a) < NREG;
    endfunction

    assign wa_ok  = wa_en && live(wa_addr);
    assign wb_ok  = wb_en && live(wb_addr);
    assign iss_ok = issue_en && live(issue_addr);
    assign rs1_ok = live(rs1_addr);
    assign rs2_ok = live(rs2_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (wb_ok) regs[wb_addr] <= wb_data;
            if (wa_ok) regs[wa_addr] <= wa_data;
        end
    end

    // A new issue outranks a same-cycle completion; flush outranks both.
    always_comb begin
        busy_nxt = busy;
        if (wb_ok) busy_nxt[wb_addr] = 1'b0;
        if (iss_ok) busy_nxt[issue_addr] = 1'b1;
        if (flush) busy_nxt = '0;
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    rf_read_port #(.XLEN(XLEN), .AW(AW)) u_rp1 (
        .addr(rs1_addr), .valid(rs1_ok),
        .stored(rs1_ok ? regs[rs1_addr] : '0), .busy_bit(rs1_ok && busy[rs1_addr]),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .data(rs1_data), .busy(rs1_busy)
    );

    rf_read_port #(.XLEN(XLEN), .AW(AW)) u_rp2 (
        .addr(rs2_addr), .valid(rs2_ok),
        .stored(rs2_ok ? regs[rs2_addr] : '0), .busy_bit(rs2_ok && busy[rs2_addr]),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .data(rs2_data), .busy(rs2_busy)
    );
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning number of architectural registers; AW = clog2(NREG).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports rs1_addr, rs2_addr  input  AW  read addresses.
REQ-006 SHALL have ports rs1_data, rs2_data  output  XLEN  read data, combinational.
REQ-007 SHALL have ports rs1_busy, rs2_busy  output  1  source has a pending long-latency write.
REQ-008 SHALL have ports wa_en (1), wa_addr (AW), wa_data (XLEN)  input  write port A: ALU/load writeback.
REQ-009 SHALL have ports wb_en (1), wb_addr (AW), wb_data (XLEN)  input  write port B: MUL/DIV writeback; clears busy.
REQ-010 SHALL have ports issue_en (1), issue_addr (AW)  input  marks a destination busy at issue of a MUL/DIV op.
REQ-011 SHALL have port flush  input  1  synchronous clear of all busy bits.
REQ-012 SHALL have port pending_cnt  output  AW+1  number of registers currently busy.

Function
REQ-013 Register 0 SHALL read as zero, SHALL ignore writes on both ports, and SHALL never be busy (issue to x0 ignored).
REQ-014 Writes SHALL take effect at the rising clk edge when the port enable is high.
REQ-015 Both ports writing the same nonzero address in one cycle: port A data SHALL be stored (younger instruction wins).
REQ-016 Reads SHALL bypass same-cycle writes: a nonzero rsN_addr matching an enabled write address SHALL return that write data, port A taking priority over port B, otherwise stored contents.
REQ-017 busy[i] SHALL be set at the clock edge when issue_en and issue_addr == i (i != 0).
REQ-018 busy[i] SHALL be cleared at the clock edge when wb_en and wb_addr == i.
REQ-019 Simultaneous issue and port-B writeback to the same address: busy SHALL remain set (new issue dominates); the data is still written.
REQ-020 Port A writes SHALL NOT modify any busy bit.
REQ-021 flush SHALL clear every busy bit at the clock edge and SHALL take priority over same-cycle issue_en; register writes in that cycle SHALL still occur.
REQ-022 rsN_busy SHALL equal busy[rsN_addr], forced low when rsN_addr == 0 or when wb_en and wb_addr == rsN_addr (bypassed completion).
REQ-023 pending_cnt SHALL equal the registered population count of busy bits, updated with the same edge as the busy bits (one-cycle latency after issue/writeback/flush).
REQ-024 Out-of-range addresses (>= NREG when NREG is not a power of two) SHALL read zero, never be busy, and their writes/issues SHALL be ignored.

Reset
REQ-025 On rst high, all registers SHALL clear to 0, all busy bits to 0, and pending_cnt to 0, immediately and independently of clk.
REQ-026 rst asserted mid-operation SHALL discard all pending busy state; no writeback arriving after reset release SHALL be rejected (it writes normally and clears an already-clear bit).

Structure
REQ-027 XLEN, NREG, AW defaults and the register-address type SHALL live in shared package rv_core_pkg.
REQ-028 Per-read-port bypass and busy qualification SHALL be one sub-module, rf_read_port, instantiated once per read port.
REQ-029 The storage array, busy vector, and pending counter SHALL reside in the top module only.

Verification
REQ-030 Reset, then wa write x5=0x1234_5678; next cycle read rs1=5 -> 0x1234_5678, rs1_busy=0.
REQ-031 Write x0=0xFFFF_FFFF via both ports; read rs1=0,rs2=0 -> 0x0, busy 0; issue to x0 -> pending_cnt stays 0.
REQ-032 Same cycle wa(x7,0xAAAA_AAAA) and wb(x7,0x5555_5555) with rs1=7 -> rs1_data=0xAAAA_AAAA that cycle and stored afterward.
REQ-033 issue x9; next cycle rs2=9 -> rs2_busy=1, pending_cnt=1; wb(x9,0xDEAD_BEEF) -> same-cycle rs2_data=0xDEAD_BEEF, rs2_busy=0; next cycle pending_cnt=0.
REQ-034 issue x3,x4,x5 over three cycles, then flush with issue x6 in the same cycle -> all busy 0, pending_cnt=0 next cycle.
REQ-035 issue x10, assert rst asynchronously between edges -> rs1_busy(10)=0, x10 reads 0, pending_cnt=0 before next edge.
